// File: rtl/half_adder_txn_sequencer.sv
// Request sequencer for the HLS half_adder core: buffers operand pairs, runs one
// ap_ctrl_hs transaction at a time, and holds each result on a valid/ready output.
module half_adder_txn_sequencer #(
  parameter int unsigned W           = 1,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic [W-1:0]     ha_a,
  output logic [W-1:0]     ha_b,
  input  logic [W-1:0]     ha_sum,
  input  logic             ha_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] txn_count,
  output logic             timeout_err,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [W-1:0]     mem_a_q [DEPTH];
  logic [W-1:0]     mem_b_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic [W-1:0]     ha_a_q, ha_b_q, sum_q;
  logic             carry_q, terr_q;
  logic [CNT_W-1:0] txn_q;
  logic             push, pop, capture, abort, txn_inc;

  assign in_ready    = (cnt_q != FULL_CNT);
  assign push        = in_valid & in_ready;
  assign pop         = (state_q == IDLE) && (cnt_q != '0);
  assign ap_start    = (state_q == START);
  assign out_valid   = (state_q == HOLD);
  assign busy        = (cnt_q != '0) || (state_q != IDLE);
  assign ha_a        = ha_a_q;
  assign ha_b        = ha_b_q;
  assign out_sum     = sum_q;
  assign out_carry   = carry_q;
  assign txn_count   = txn_q;
  assign timeout_err = terr_q;

  // Completion takes priority over the timeout on the same cycle; ap_done in
  // START implies the core also took the inputs.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    capture = 1'b0;
    abort   = 1'b0;
    txn_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          state_d = START;
          tcnt_d  = '0;
        end
      end
      START, WAIT: begin
        if (ap_done) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (tcnt_q == TMO_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if ((state_q == START) && ap_ready) state_d = WAIT;
        end
      end
      HOLD: begin
        if (out_ready) begin
          txn_inc = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ha_a_q   <= '0;
      ha_b_q   <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      txn_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        ha_a_q   <= mem_a_q[rd_ptr_q];
        ha_b_q   <= mem_b_q[rd_ptr_q];
      end
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (capture) begin
        sum_q   <= ha_sum;
        carry_q <= ha_carry;
      end
      if (txn_inc) txn_q  <= txn_q + 1'b1;
      if (abort)   terr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_half_adder_txn_sequencer.sv
// Scoreboard bench for half_adder_txn_sequencer with a programmable-latency core model.
module tb_half_adder_txn_sequencer;
  localparam int unsigned W = 1;

  logic clock = 1'b0;
  logic reset, in_valid, in_ready, ap_start, ap_ready, ap_done;
  logic [W-1:0] in_a, in_b, ha_a, ha_b, ha_sum, out_sum;
  logic ha_carry, out_valid, out_ready, out_carry, timeout_err, busy;
  logic [15:0] txn_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_txn  = 0;
  logic [W:0] exp_q[$];

  // Core model: ready after rdy_dly cycles of ap_start, done done_dly cycles after ready.
  logic core_rdy_en, never_done, extra_done;
  int unsigned rdy_dly, done_dly, cc;
  logic cst, core_rdy, core_done;
  logic [W:0] core_res;

  always #5 clock = ~clock;

  half_adder_txn_sequencer #(.W(W), .DEPTH(4), .TIMEOUT_CYC(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ha_a(ha_a), .ha_b(ha_b), .ha_sum(ha_sum), .ha_carry(ha_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
    .txn_count(txn_count), .timeout_err(timeout_err), .busy(busy)
  );

  always_comb begin
    core_rdy  = ap_start && !cst && core_rdy_en && (cc == rdy_dly);
    core_done = 1'b0;
    if (!never_done) core_done = (core_rdy && done_dly == 0) || (cst && cc == done_dly);
    core_res  = ha_a + ha_b;
  end
  assign ap_ready = core_rdy;
  assign ap_done  = core_done | extra_done;
  // Outputs are deliberately wrong except on the core's own done cycle.
  assign ha_sum   = core_done ? core_res[W-1:0] : ~core_res[W-1:0];
  assign ha_carry = core_done ? core_res[W] : ~core_res[W];

  always @(posedge clock) begin
    if (reset) begin
      cst <= 1'b0; cc <= 0;
    end else if (!cst) begin
      if (core_rdy) begin
        if (core_done) cc <= 0;
        else begin cst <= 1'b1; cc <= 1; end
      end else if (ap_start) cc <= cc + 1;
      else cc <= 0;
    end else begin
      if (core_done) begin cst <= 1'b0; cc <= 0; end
      else cc <= cc + 1;
    end
  end

  // Scoreboard: compare every handed-off result against the queued expectation.
  always @(negedge clock) begin
    if (out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got carry=%b sum=%0h with no expected result queued", out_carry, out_sum);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({out_carry, out_sum} !== e) begin
          n_fail++;
          $display("FAIL sb_result: got carry=%b sum=%0h expected carry=%b sum=%0h",
                   out_carry, out_sum, e[W], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    int g;
    logic [W:0] e;
    in_a = a; in_b = b; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin tick(); g++; end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL push_accept: in_ready=%b expected 1 within 50 cycles", in_ready);
    end else if (keep) begin
      e = {1'b0, a} + {1'b0, b};
      exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    core_rdy_en = 1'b1; never_done = 1'b0; extra_done = 1'b0; rdy_dly = 0; done_dly = 0;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++;
    if ({in_ready, ap_start, out_valid, timeout_err, busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready,ap_start,out_valid,timeout_err,busy=%b expected 10000",
               {in_ready, ap_start, out_valid, timeout_err, busy});
    end
    n_checks++;
    if ({txn_count, ha_a, ha_b, out_sum, out_carry} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: txn=%0d ha_a=%0h ha_b=%0h sum=%0h carry=%b expected all 0",
               txn_count, ha_a, ha_b, out_sum, out_carry);
    end
  endtask

  task automatic test_single;
    push(1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({ap_start, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_queued: ap_start,busy=%b expected 01", {ap_start, busy});
    end
    tick();
    n_checks++;
    if ({ap_start, ha_a, ha_b} !== 3'b111) begin
      n_fail++;
      $display("FAIL single_start: ap_start,ha_a,ha_b=%b expected 111", {ap_start, ha_a, ha_b});
    end
    tick();
    n_checks++;
    if ({out_valid, ap_start} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_latency: out_valid,ap_start=%b expected 10", {out_valid, ap_start});
    end
    tick();
    exp_txn++;
    n_checks++;
    if (out_valid !== 1'b0 || txn_count !== 16'(exp_txn)) begin
      n_fail++;
      $display("FAIL single_count: out_valid=%b txn=%0d expected 0/%0d", out_valid, txn_count, exp_txn);
    end
  endtask

  task automatic test_fill;
    int g;
    logic [1:0] pat [5];
    pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b11; pat[4] = 2'b11;
    rdy_dly = 6; done_dly = 0;
    for (int i = 0; i < 5; i++) push(pat[i][1], pat[i][0], 1'b1);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: in_ready=%b expected 0 after 5 accepted", in_ready);
    end
    exp_txn += 5;
    g = 0;
    while (txn_count !== 16'(exp_txn) && g < 100) begin tick(); g++; end
    n_checks++;
    if (txn_count !== 16'(exp_txn) || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fill_drain: txn=%0d pending=%0d expected %0d/0", txn_count, exp_q.size(), exp_txn);
    end
    n_checks++;
    if ({timeout_err, busy, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL fill_idle: timeout_err,busy,in_ready=%b expected 001", {timeout_err, busy, in_ready});
    end
  endtask

  task automatic test_delayed_core;
    int g, hi;
    rdy_dly = 2; done_dly = 2;
    push(1'b0, 1'b1, 1'b1);
    g = 0; hi = 0;
    while (out_valid !== 1'b1 && g < 30) begin
      tick(); g++;
      if (ap_start === 1'b1) hi++;
    end
    n_checks++;
    if (hi != 3 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL delayed_start_len: ap_start cycles=%0d out_valid=%b expected 3/1", hi, out_valid);
    end
    tick();
    exp_txn++;
    n_checks++;
    if (txn_count !== 16'(exp_txn)) begin
      n_fail++;
      $display("FAIL delayed_count: txn=%0d expected %0d", txn_count, exp_txn);
    end
  endtask

  task automatic test_backpressure;
    int g;
    rdy_dly = 0; done_dly = 0; out_ready = 1'b0;
    push(1'b1, 1'b0, 1'b1);
    push(1'b1, 1'b1, 1'b1);
    g = 0;
    while (out_valid !== 1'b1 && g < 20) begin tick(); g++; end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({out_valid, out_carry, out_sum, ap_start} !== 4'b1010 || txn_count !== 16'(exp_txn)) begin
        n_fail++;
        $display("FAIL bp_hold: valid,carry,sum,ap_start=%b txn=%0d expected 1010/%0d",
                 {out_valid, out_carry, out_sum, ap_start}, txn_count, exp_txn);
      end
      tick();
    end
    out_ready = 1'b1;
    exp_txn += 2;
    g = 0;
    while (txn_count !== 16'(exp_txn) && g < 30) begin tick(); g++; end
    n_checks++;
    if (txn_count !== 16'(exp_txn)) begin
      n_fail++;
      $display("FAIL bp_release: txn=%0d expected %0d", txn_count, exp_txn);
    end
  endtask

  task automatic test_timeout;
    int g, hi;
    core_rdy_en = 1'b0;
    push(1'b1, 1'b1, 1'b0);
    g = 0; hi = 0;
    while (timeout_err !== 1'b1 && g < 40) begin
      tick(); g++;
      if (ap_start === 1'b1) hi++;
    end
    n_checks++;
    if (hi != 8 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_len: ap_start cycles=%0d timeout_err=%b expected 8/1", hi, timeout_err);
    end
    n_checks++;
    if ({ap_start, busy, out_valid} !== 3'b000 || txn_count !== 16'(exp_txn)) begin
      n_fail++;
      $display("FAIL timeout_idle: ap_start,busy,out_valid=%b txn=%0d expected 000/%0d",
               {ap_start, busy, out_valid}, txn_count, exp_txn);
    end
    core_rdy_en = 1'b1; rdy_dly = 0; done_dly = 1;
    push(1'b0, 1'b1, 1'b1);
    exp_txn++;
    g = 0;
    while (txn_count !== 16'(exp_txn) && g < 30) begin tick(); g++; end
    n_checks++;
    if (txn_count !== 16'(exp_txn) || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_recover: txn=%0d timeout_err=%b expected %0d/1", txn_count, timeout_err, exp_txn);
    end
  endtask

  task automatic test_reset_mid_wait;
    int g;
    rdy_dly = 0; done_dly = 5;
    push(1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1);
    g = 0;
    while (ap_start !== 1'b1 && g < 20) begin tick(); g++; end
    tick();
    n_checks++;
    if ({ap_start, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_in_wait: ap_start,busy=%b expected 01", {ap_start, busy});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_txn = 0;
    n_checks++;
    if ({in_ready, ap_start, out_valid, timeout_err, busy} !== 5'b10000 ||
        {txn_count, ha_a, ha_b, out_sum, out_carry} !== '0) begin
      n_fail++;
      $display("FAIL rst_values: flags=%b txn=%0d ha_a=%0h ha_b=%0h sum=%0h carry=%b expected 10000/0",
               {in_ready, ap_start, out_valid, timeout_err, busy}, txn_count, ha_a, ha_b, out_sum, out_carry);
    end
    extra_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({out_valid, busy, out_sum, out_carry} !== 4'b0000) begin
        n_fail++;
        $display("FAIL rst_late_done: valid,busy,sum,carry=%b expected 0000",
                 {out_valid, busy, out_sum, out_carry});
      end
    end
    extra_done = 1'b0;
    done_dly = 0;
    push(1'b1, 1'b1, 1'b1);
    exp_txn++;
    g = 0;
    while (txn_count !== 16'(exp_txn) && g < 30) begin tick(); g++; end
    n_checks++;
    if (txn_count !== 16'(exp_txn) || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_after: txn=%0d pending=%0d expected %0d/0", txn_count, exp_q.size(), exp_txn);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_delayed_core();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
